// File: rtl/stochastic_addsub_array.sv
// stochastic_addsub_array: NUM_CH parallel stochastic scaled add/subtract lanes.
// Define SC_INTERNAL_SEL_EN to draw the shared select from an internal 16-bit LFSR.
module stochastic_addsub_array #(
    parameter int NUM_CH     = 4,
    parameter int BIT_LENGTH = 128,
    localparam int CNT_W     = $clog2(BIT_LENGTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]       a_i,
    input  logic [NUM_CH-1:0]       b_i,
    input  logic                    sel_i,
    input  logic                    bit_valid_i,
    output logic                    bit_ready_o,
    output logic [NUM_CH-1:0]       y_o,
    output logic                    y_valid_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BIT_LENGTH);

    state_t            state_q;
    state_t            state_d;
    logic              in_run;
    logic              accept;
    logic              start_acc;
    logic              last_bit;
    logic              sel;
    logic [CNT_W-1:0]  idx_q;
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] y_d;
    logic [NUM_CH-1:0] y_q;
    logic              y_valid_q;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    assign in_run    = (state_q == RUN);
    assign accept    = in_run && bit_valid_i;
    assign start_acc = start_i && !in_run;
    assign last_bit  = accept && (idx_q == LAST_IDX);

`ifdef SC_INTERNAL_SEL_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    logic        unused_sel_i;

    // Fibonacci taps 16,14,13,11 in right-shift orientation
    assign lfsr_fb      = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign sel          = lfsr_q[0];
    assign unused_sel_i = sel_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (start_acc) begin
            lfsr_q <= LFSR_SEED;
        end else if (accept) begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end
`else
    assign sel = sel_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (last_bit) state_d = DONE;
            DONE: if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // subtract lanes invert b so the mux yields bipolar (a-b)/2
    always_comb begin
        y_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel) begin
                y_d[c] = a_i[c];
            end else begin
                y_d[c] = b_i[c] ^ mode_q[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            idx_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= accept;
            if (start_acc) begin
                mode_q <= mode_i;
                idx_q  <= '0;
            end else if (accept) begin
                idx_q <= idx_q + 1'b1;
                y_q   <= y_d;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[c] <= '0;
            end else if (start_acc) begin
                cnt_q[c] <= '0;
            end else if (accept && y_d[c] && (cnt_q[c] != CNT_MAX)) begin
                cnt_q[c] <= cnt_q[c] + 1'b1;
            end
        end

        assign count_o[c*CNT_W +: CNT_W] = cnt_q[c];
    end

    assign bit_ready_o = in_run;
    assign busy_o      = in_run;
    assign done_o      = (state_q == DONE);
    assign y_o         = y_q;
    assign y_valid_o   = y_valid_q;

endmodule

// File: tb/tb_stochastic_addsub_array.sv
// tb_stochastic_addsub_array: random and directed streams checked every cycle
// against a position-based behavioural model of the stochastic lanes.
module tb_stochastic_addsub_array;

    localparam int NUM_CH   = 4;
    localparam int BL       = 128;
    localparam int CNT_W    = $clog2(BL + 1);
    localparam int SEL_ALT  = 0;
    localparam int SEL_ZERO = 1;
    localparam int SEL_ONE  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start_i = 1'b0;
    logic [NUM_CH-1:0]       mode_i = '0;
    logic [NUM_CH-1:0]       a_i = '0;
    logic [NUM_CH-1:0]       b_i = '0;
    logic                    sel_i = 1'b0;
    logic                    bit_valid_i = 1'b0;
    logic                    bit_ready_o;
    logic [NUM_CH-1:0]       y_o;
    logic                    y_valid_o;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic                    busy_o;
    logic                    done_o;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // model: 0 idle, 1 run, 2 done; m_pos = bits accepted in this stream
    int                m_state;
    int                m_pos;
    int                m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_mode;
    logic [NUM_CH-1:0] m_y;
    logic              m_yv;
    logic              m_seq [BL];

    stochastic_addsub_array #(
        .NUM_CH(NUM_CH),
        .BIT_LENGTH(BL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .mode_i(mode_i),
        .a_i(a_i),
        .b_i(b_i),
        .sel_i(sel_i),
        .bit_valid_i(bit_valid_i),
        .bit_ready_o(bit_ready_o),
        .y_o(y_o),
        .y_valid_o(y_valid_o),
        .count_o(count_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH*CNT_W-1:0] model_count();
        logic [NUM_CH*CNT_W-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_pos   = 0;
            m_mode  = '0;
            m_y     = '0;
            m_yv    = 1'b0;
            foreach (m_cnt[c]) m_cnt[c] = 0;
        end else begin
            m_yv = 1'b0;
            if (m_state == 1) begin
                if (bit_valid_i) begin
                    logic s;
`ifdef SC_INTERNAL_SEL_EN
                    s = m_seq[m_pos];
`else
                    s = sel_i;
`endif
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (s) m_y[c] = a_i[c];
                        else if (m_mode[c]) m_y[c] = !b_i[c];
                        else m_y[c] = b_i[c];
                        m_cnt[c] = m_cnt[c] + int'(m_y[c]);
                    end
                    m_yv  = 1'b1;
                    m_pos = m_pos + 1;
                    if (m_pos == BL) m_state = 2;
                end
            end else if (start_i) begin
                m_mode  = mode_i;
                m_pos   = 0;
                m_state = 1;
                foreach (m_cnt[c]) m_cnt[c] = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (cmp_en) begin
                check("busy", busy_o, m_state == 1);
                check("ready", bit_ready_o, m_state == 1);
                check("done", done_o, m_state == 2);
                check("y_valid", y_valid_o, m_yv);
                check("count", count_o, model_count());
                if (m_yv) check("y", y_o, m_y);
            end
        end
    end

    task automatic drive(input logic st, input logic [3:0] md, input logic [3:0] a,
                         input logic [3:0] b, input logic s, input logic v);
        start_i     = st;
        mode_i      = md;
        a_i         = a;
        b_i         = b;
        sel_i       = s;
        bit_valid_i = v;
        @(negedge clk);
    endtask

    task automatic lit4(input string name, input int c0, input int c1, input int c2, input int c3);
`ifndef SC_INTERNAL_SEL_EN
        check({name, " ch0"}, count_o[0*CNT_W +: CNT_W], c0);
        check({name, " ch1"}, count_o[1*CNT_W +: CNT_W], c1);
        check({name, " ch2"}, count_o[2*CNT_W +: CNT_W], c2);
        check({name, " ch3"}, count_o[3*CNT_W +: CNT_W], c3);
        check({name, " model ch0"}, m_cnt[0], c0);
        check({name, " model ch3"}, m_cnt[3], c3);
`endif
    endtask

    task automatic run_fixed(input logic [3:0] md, input logic [3:0] a, input logic [3:0] b,
                             input int sm, input int inj);
        drive(1'b1, md, 4'h0, 4'h0, 1'b0, 1'b0);
        check("start clears count", count_o, 0);
        check("start busy", busy_o, 1);
        for (int n = 0; n < BL; n++) begin
            logic s;
            s = (sm == SEL_ALT) ? (n % 2 == 0) : (sm == SEL_ONE);
            drive(n == inj, ~md, a, b, s, 1'b1);
        end
        check("done after last bit", done_o, 1);
        check("last y_valid", y_valid_o, 1);
    endtask

    initial begin
        logic [15:0] r;
        int done_cyc;
        int acc;
        int guard;
        int ones;
        int exp_lfsr;
        logic [NUM_CH*CNT_W-1:0] first_cnt;

        r = 16'hACE1;
        for (int k = 0; k < BL; k++) begin
            m_seq[k] = r[0];
            r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
        end

        @(negedge clk);
        check("reset y", y_o, 0);
        check("reset y_valid", y_valid_o, 0);
        check("reset count", count_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset ready", bit_ready_o, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        drive(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
        check("idle ignores bits", count_o, 0);

        run_fixed(4'b0000, 4'hF, 4'h0, SEL_ALT, -1);
        lit4("add", 64, 64, 64, 64);
        run_fixed(4'b1111, 4'hF, 4'b1001, SEL_ZERO, -1);
        lit4("sub", 0, 128, 128, 0);
        run_fixed(4'b0101, 4'hF, 4'h0, SEL_ZERO, -1);
        lit4("mixed", 128, 0, 128, 0);
        run_fixed(4'b0000, 4'hF, 4'h0, SEL_ALT, 40);
        lit4("start in run", 64, 64, 64, 64);

        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        done_cyc = -1;
        acc      = 0;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            logic v;
            v = (cyc % 2 == 0);
            drive(1'b0, 4'h0, 4'hF, 4'h0, v ? (acc % 2 == 0) : 1'($urandom_range(0, 1)), v);
            if (v) acc++;
            if (done_o) done_cyc = cyc + 1;
        end
        check("stall done cycle", done_cyc, 255);
        lit4("stall", 64, 64, 64, 64);

        drive(1'b1, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b0);
        for (int n = 0; n < 50; n++) begin
            drive(1'b0, 4'h0, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        rst_n = 1'b0;
        #1;
        check("midreset y", y_o, 0);
        check("midreset y_valid", y_valid_o, 0);
        check("midreset count", count_o, 0);
        check("midreset busy", busy_o, 0);
        check("midreset done", done_o, 0);
        check("midreset ready", bit_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        for (int rr = 0; rr < 4; rr++) begin
            drive(1'b1, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'($urandom_range(0, 1)));
            guard = 0;
            while (!done_o && guard < 1000) begin
                drive(($urandom % 8) == 0, 4'($urandom), 4'($urandom), 4'($urandom),
                      1'($urandom_range(0, 1)), ($urandom % 4) != 0);
                guard++;
            end
            check("random run done", done_o, 1);
            for (int n = 0; n < 3; n++) begin
                drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        ones = 0;
        for (int k = 0; k < BL; k++) ones += int'(m_seq[k]);
`ifdef SC_INTERNAL_SEL_EN
        exp_lfsr = ones;
`else
        exp_lfsr = BL;
`endif
        run_fixed(4'b0000, 4'hF, 4'h0, SEL_ONE, -1);
        first_cnt = count_o;
        for (int c = 0; c < NUM_CH; c++) begin
            check("sel source count", count_o[c*CNT_W +: CNT_W], exp_lfsr);
        end
        run_fixed(4'b0000, 4'hF, 4'h0, SEL_ONE, -1);
        check("sel source repeat", count_o, first_cnt);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
